// File: rtl/elevator_controller.sv
// Single-car elevator controller: latches floor requests, sweeps in the current
// direction while requests remain beyond the car, and holds the door open on arrival.
module elevator_controller #(
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_floor,
  input  logic [3:0]  cur_floor,
  output logic        move_en,
  output logic        move_up,
  output logic        door_open,
  output logic [1:0]  state,
  output logic [15:0] pending
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  localparam logic [7:0] TRAVEL_LAST = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LAST   = 8'(DOOR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic        dir_q, dir_d;
  logic [15:0] pending_q, pending_d;

  logic [15:0] floor_bit, upto_mask, above_mask, below_mask, set_mask, clr_mask;
  logic        has_above, has_below, here_req, door_restart, clear_here;
  logic        going_up, beyond, at_end;

  // Masks of floors strictly above / below the car; at floor 15 the shift
  // overflows to zero so upto_mask becomes all ones and nothing is "above".
  assign floor_bit  = 16'd1 << cur_floor;
  assign upto_mask  = (floor_bit << 1) - 16'd1;
  assign above_mask = ~upto_mask;
  assign below_mask = floor_bit - 16'd1;
  assign has_above  = |(pending_q & above_mask);
  assign has_below  = |(pending_q & below_mask);
  assign here_req   = pending_q[cur_floor];

  assign going_up = (state_q == MOVE_UP);
  assign beyond   = going_up ? has_above : has_below;
  assign at_end   = going_up ? (cur_floor == 4'd15) : (cur_floor == 4'd0);

  // A call for the floor the door is already open at just extends the door time.
  assign door_restart = (state_q == DOOR_OPEN) && req_valid && (req_floor == cur_floor);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    dir_d      = dir_q;
    clear_here = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = 8'd0;
        if (here_req) begin
          state_d    = DOOR_OPEN;
          clear_here = 1'b1;
        end else if (has_above && (dir_q || !has_below)) begin
          state_d = MOVE_UP;
          dir_d   = 1'b1;
        end else if (has_below) begin
          state_d = MOVE_DOWN;
          dir_d   = 1'b0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (timer_q == 8'd0 && here_req) begin
          state_d    = DOOR_OPEN;
          timer_d    = 8'd0;
          clear_here = 1'b1;
        end else if ((timer_q == 8'd0 && !beyond) || at_end) begin
          state_d = IDLE;
          timer_d = 8'd0;
        end else if (timer_q == TRAVEL_LAST) begin
          timer_d = 8'd0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      DOOR_OPEN: begin
        if (door_restart) begin
          timer_d = 8'd0;
        end else if (timer_q == DOOR_LAST) begin
          state_d = IDLE;
          timer_d = 8'd0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clearing the serviced floor overrides a same-cycle request for it.
  assign set_mask  = (req_valid && !door_restart) ? (16'd1 << req_floor) : 16'd0;
  assign clr_mask  = clear_here ? floor_bit : 16'd0;
  assign pending_d = (pending_q | set_mask) & ~clr_mask;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= 8'd0;
      dir_q     <= 1'b1;
      pending_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
    end
  end

  // Outputs are pure decodes of registered state.
  assign move_en   = (state_q == MOVE_UP || state_q == MOVE_DOWN) && (timer_q == TRAVEL_LAST);
  assign move_up   = dir_q;
  assign door_open = (state_q == DOOR_OPEN);
  assign state     = state_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench for elevator_controller: scenarios queue expected step/door
// events; a monitor pops and compares each one as the DUT produces it.
module tb_elevator_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_floor;
  logic [3:0]  cur_floor = 4'd0;
  logic        move_en, move_up, door_open;
  logic [1:0]  state;
  logic [15:0] pending;

  logic        jump_en;
  logic [3:0]  jump_val;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  elevator_controller #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
    .cur_floor(cur_floor), .move_en(move_en), .move_up(move_up),
    .door_open(door_open), .state(state), .pending(pending)
  );

  always #5 clk = ~clk;

  // Downstream floor counter, with a bench-side jump to place the car.
  always @(posedge clk) begin
    if (jump_en)                        cur_floor <= jump_val;
    else if (move_en && move_up)        cur_floor <= cur_floor + 4'd1;
    else if (move_en && !move_up)       cur_floor <= cur_floor - 4'd1;
  end

  function automatic logic [31:0] enc(input logic is_door, input logic up,
                                      input logic [3:0] floor, input logic [15:0] len);
    return {7'd0, is_door, 3'd0, up, 4'd0, floor, len[11:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_move(input logic up, input logic [3:0] floor);
    exp_q.push_back(enc(1'b0, up, floor, 16'd0));
  endtask

  task automatic push_door(input logic [3:0] floor, input int len);
    exp_q.push_back(enc(1'b1, 1'b0, floor, 16'(len)));
  endtask

  task automatic send_req(input logic [3:0] f);
    @(posedge clk); #1 req_valid = 1'b1; req_floor = f;
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic jump_to(input logic [3:0] f);
    @(posedge clk); #1 jump_en = 1'b1; jump_val = f;
    @(posedge clk); #1 jump_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (!(state == 2'd0 && pending == 16'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check({name, "_timeout"}, 32'(n), 32'(0));
    repeat (2) @(negedge clk);
    check({name, "_events_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compares every step pulse and every completed door cycle.
  logic        door_prev = 1'b0;
  int          door_len  = 0;
  logic [3:0]  door_floor = 4'd0;
  always @(negedge clk) begin
    if (reset) begin
      door_prev = 1'b0;
    end else begin
      if (move_en || door_open) check("door_move_excl", 32'(move_en & door_open), 32'd0);
      if (move_en) begin
        if (exp_q.size() == 0) check("unexpected_move", enc(1'b0, move_up, cur_floor, 16'd0), 32'hFFFF_FFFF);
        else check("move_event", enc(1'b0, move_up, cur_floor, 16'd0), exp_q.pop_front());
      end
      if (door_open) begin
        if (!door_prev) begin
          door_len   = 0;
          door_floor = cur_floor;
        end
        door_len++;
      end else if (door_prev) begin
        if (exp_q.size() == 0) check("unexpected_door", enc(1'b1, 1'b0, door_floor, 16'(door_len)), 32'hFFFF_FFFF);
        else check("door_event", enc(1'b1, 1'b0, door_floor, 16'(door_len)), exp_q.pop_front());
      end
      door_prev = door_open;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int pulses;
    reset = 1'b1; req_valid = 1'b0; req_floor = 4'd0; jump_en = 1'b0; jump_val = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_state",   32'(state),     32'd0);
    check("reset_pending", 32'(pending),   32'd0);
    check("reset_move_en", 32'(move_en),   32'd0);
    check("reset_move_up", 32'(move_up),   32'd1);
    check("reset_door",    32'(door_open), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Floor 0 to floor 3: three up-steps four cycles apart, then an 8-cycle door.
    jump_to(4'd0);
    push_move(1'b1, 4'd0); push_move(1'b1, 4'd1); push_move(1'b1, 4'd2);
    push_door(4'd3, 8);
    send_req(4'd3);
    @(negedge clk);
    check("pending_latch", 32'(pending), 32'h0008);
    lat = 1;
    while (!move_en && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("first_move_latency", 32'(lat), 32'd5);
    wait_idle("to_floor3", 200);

    // Call at the current floor opens the door without moving.
    jump_to(4'd5);
    push_door(4'd5, 8);
    send_req(4'd5);
    @(negedge clk);
    @(negedge clk);
    check("same_floor_door", 32'(state), 32'd3);
    wait_idle("same_floor", 100);

    // Re-call at door timer 6 restarts the door: 7 + 8 cycles open.
    push_door(4'd5, 15);
    send_req(4'd5);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!door_open && lat < 20);
    repeat (6) @(posedge clk);
    #1 req_valid = 1'b1; req_floor = 4'd5;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("restart_no_pending", 32'(pending), 32'd0);
    wait_idle("door_restart", 100);

    // From 4 heading to 9: stop at 6, continue to 9, reverse down to 2.
    jump_to(4'd4);
    push_move(1'b1, 4'd4); push_move(1'b1, 4'd5); push_door(4'd6, 8);
    push_move(1'b1, 4'd6); push_move(1'b1, 4'd7); push_move(1'b1, 4'd8); push_door(4'd9, 8);
    for (int f = 9; f >= 3; f--) push_move(1'b0, 4'(f));
    push_door(4'd2, 8);
    send_req(4'd9);
    lat = 0;
    while (state != 2'd1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("sweep_move_up", 32'(state), 32'd1);
    send_req(4'd6);
    send_req(4'd2);
    wait_idle("sweep", 400);
    check("sweep_dir_down", 32'(move_up), 32'd0);

    // At 7 with dir=0 and calls for 0 and 15: serve 0 first, then 15.
    jump_to(4'd7);
    push_door(4'd7, 8);
    for (int f = 7; f >= 1; f--) push_move(1'b0, 4'(f));
    push_door(4'd0, 8);
    for (int f = 0; f <= 14; f++) push_move(1'b1, 4'(f));
    push_door(4'd15, 8);
    send_req(4'd7);
    lat = 0;
    while (!door_open && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    send_req(4'd15);
    send_req(4'd0);
    @(negedge clk);
    check("both_pending", 32'(pending), 32'h8001);
    wait_idle("dir_priority", 800);

    // Reset in the middle of a step discards the request for floor 8.
    jump_to(4'd0);
    send_req(4'd8);
    @(negedge clk);
    check("pre_reset_pending", 32'(pending), 32'h0100);
    lat = 0;
    while (state != 2'd1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midstep_state",   32'(state),     32'd0);
    check("midstep_pending", 32'(pending),   32'd0);
    check("midstep_move_en", 32'(move_en),   32'd0);
    check("midstep_move_up", 32'(move_up),   32'd1);
    check("midstep_door",    32'(door_open), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (move_en) pulses++;
    end
    check("no_move_after_reset", 32'(pulses), 32'd0);
    check("idle_after_reset", 32'(state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
